snitch_icache_refill_arbiter: RTL and testbench
===============================================

Name: snitch_icache_refill_arbiter

Overview:
- Shares the single L1 lookup/refill port of the instruction cache between NR_FETCH_PORTS L0 caches.
- Arbitrates L0 miss requests round-robin, tags each request with the port index as ID, and routes L1 responses back by ID.
- Tracks outstanding requests per port and sequences a cache flush: it drains in-flight traffic before acknowledging the flush.
- Sits between the per-core L0 instances and the shared L1 lookup stage.

Parameters:
- NR_FETCH_PORTS, 2, number of L0 requesters (1..16).
- FETCH_AW, 32, request address width.
- LINE_WIDTH, 128, response line width in bits.
- MAX_OUTSTANDING, 4, maximum in-flight requests per port (1..15).
- ID_WIDTH, max(1, clog2(NR_FETCH_PORTS)), width of the request/response ID.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_addr_i  in  NR_FETCH_PORTS*FETCH_AW  per-port miss address.
- in_valid_i  in  NR_FETCH_PORTS  per-port request valid.
- in_ready_o  out  NR_FETCH_PORTS  per-port request ready.
- in_rsp_data_o  out  NR_FETCH_PORTS*LINE_WIDTH  per-port response line (broadcast of out_rsp_data_i).
- in_rsp_error_o  out  NR_FETCH_PORTS  per-port response error.
- in_rsp_valid_o  out  NR_FETCH_PORTS  per-port response valid.
- in_rsp_ready_i  in  NR_FETCH_PORTS  per-port response ready.
- out_addr_o  out  FETCH_AW  L1 request address.
- out_id_o  out  ID_WIDTH  L1 request ID (index of the granted port).
- out_valid_o  out  1  L1 request valid.
- out_ready_i  in  1  L1 request ready.
- out_rsp_data_i  in  LINE_WIDTH  L1 response line.
- out_rsp_error_i  in  1  L1 response error.
- out_rsp_id_i  in  ID_WIDTH  L1 response ID.
- out_rsp_valid_i  in  1  L1 response valid.
- out_rsp_ready_o  out  1  L1 response ready.
- flush_valid_i  in  1  flush request.
- flush_ready_o  out  1  flush acknowledge; drain is complete.
- stall_o  out  1  event: out_valid_o && !out_ready_i.
- protocol_error_o  out  1  sticky; set on an unexpected response.

Behaviour:
- Reset:
  - State IDLE, round-robin pointer 0, all outstanding counters 0, lock register clear, protocol_error_o 0.
  - During reset and in the cycle after, all valids and readies are 0, except out_rsp_ready_o, which is 1 (sink).
- Eligibility: port p is eligible when in_valid_i[p] is 1, cnt[p] < MAX_OUTSTANDING, and state is IDLE.
- Arbitration:
  - Combinational, zero latency.
  - Winner is the first eligible port at or after the pointer, with wrap-around.
  - out_valid_o is 1 when any port is eligible or the lock is held.
  - out_addr_o and out_id_o come from the winner. in_ready_o[winner] equals out_ready_i; all other in_ready_o bits are 0.
- Lock:
  - If out_valid_o is 1 and out_ready_i is 0, the grant is registered and held until the handshake completes.
  - While locked, out_addr_o and out_id_o stay stable and the same port stays selected, even if a flush arrives or a higher-priority port becomes valid.
  - The locked port's in_valid_i must stay high; the bench treats a drop as a violation.
- Pointer: on a request handshake, pointer becomes winner+1 modulo NR_FETCH_PORTS. Otherwise it is unchanged.
- Outstanding counters (width clog2(MAX_OUTSTANDING+1)):
  - cnt[p] increments on a request handshake from p and decrements on a response handshake to p.
  - If both happen in the same cycle, cnt[p] is unchanged.
  - cnt[p] never exceeds MAX_OUTSTANDING and never underflows.
- Response routing:
  - Let r = out_rsp_id_i. If r < NR_FETCH_PORTS and cnt[r] > 0:
    - in_rsp_valid_o[r] = out_rsp_valid_i.
    - out_rsp_ready_o = in_rsp_ready_i[r].
    - in_rsp_error_o[r] = out_rsp_error_i.
  - Otherwise the response is sunk: out_rsp_ready_o = 1, no in_rsp_valid_o is asserted, and protocol_error_o is set on the cycle after the handshake.
  - protocol_error_o clears only on reset.
  - Responses are always accepted, in any state.
- Flush FSM:
  - IDLE → DRAIN when flush_valid_i is 1. Grants stop in the same cycle; a locked request still completes.
  - DRAIN → DONE when all cnt are 0, the lock is clear, and no request handshake occurs that cycle.
  - DRAIN → IDLE if flush_valid_i drops.
  - DONE: flush_ready_o = 1. Go to IDLE on the flush handshake (flush_valid_i = 1), or if flush_valid_i drops.
  - flush_ready_o is 0 in all other states.
  - Minimum flush latency with nothing outstanding: flush_ready_o rises 2 cycles after flush_valid_i rises.
- Reset mid-operation:
  - All counters clear.
  - Late L1 responses are sunk and set protocol_error_o.

Test Plan:
- Fairness: NR_FETCH_PORTS=2, both ports valid continuously, out_ready_i=1 → grants alternate 0,1,0,1 and out_id_o toggles every cycle.
- Lock: port 0 requests 0x1000 and out_ready_i=0 for 3 cycles while port 1 becomes valid → out_addr_o stays 0x1000 and out_id_o stays 0 until the handshake; port 1 is granted next.
- Backpressure limit: port 0 issues 4 requests with no responses → in_ready_o[0]=0 on the 5th attempt. One response to ID 0 → port 0 is eligible again the next cycle.
- Routing: response with ID 1, data 0xDEAD_BEEF, error=1, in_rsp_ready_i[1]=0 for 2 cycles → in_rsp_valid_o[1] held and out_rsp_ready_o=0 for those cycles; cnt[1] decrements only on the handshake.
- Flush drain: 2 outstanding for port 0, flush_valid_i=1 → no grants issued; flush_ready_o=1 exactly 1 cycle after the second response handshake; IDLE after the flush handshake.
- Error: response with ID 1 while cnt[1]=0 → sunk, no in_rsp_valid_o asserted, protocol_error_o=1 until rst_i.

Source files
------------

// File: rtl/snitch_icache_refill_arbiter.sv
// rtl/snitch_icache_refill_arbiter.sv - round-robin L0-to-L1 refill arbiter with response routing and flush drain
module snitch_icache_refill_arbiter #(
  parameter int unsigned NR_FETCH_PORTS  = 2,
  parameter int unsigned FETCH_AW        = 32,
  parameter int unsigned LINE_WIDTH      = 128,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ID_WIDTH        = (NR_FETCH_PORTS > 1) ? $clog2(NR_FETCH_PORTS) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NR_FETCH_PORTS*FETCH_AW-1:0]   in_addr_i,
  input  logic [NR_FETCH_PORTS-1:0]            in_valid_i,
  output logic [NR_FETCH_PORTS-1:0]            in_ready_o,
  output logic [NR_FETCH_PORTS*LINE_WIDTH-1:0] in_rsp_data_o,
  output logic [NR_FETCH_PORTS-1:0]            in_rsp_error_o,
  output logic [NR_FETCH_PORTS-1:0]            in_rsp_valid_o,
  input  logic [NR_FETCH_PORTS-1:0]            in_rsp_ready_i,
  output logic [FETCH_AW-1:0]                  out_addr_o,
  output logic [ID_WIDTH-1:0]                  out_id_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  input  logic [LINE_WIDTH-1:0]                out_rsp_data_i,
  input  logic                                 out_rsp_error_i,
  input  logic [ID_WIDTH-1:0]                  out_rsp_id_i,
  input  logic                                 out_rsp_valid_i,
  output logic                                 out_rsp_ready_o,
  input  logic                                 flush_valid_i,
  output logic                                 flush_ready_o,
  output logic                                 stall_o,
  output logic                                 protocol_error_o
);

  localparam int NP = int'(NR_FETCH_PORTS);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [ID_WIDTH-1:0] lock_idx_q, winner;
  logic                lock_q, init_q, perr_q;
  logic [CW-1:0]       cnt_q [NR_FETCH_PORTS];
  logic [CW-1:0]       cnt_d [NR_FETCH_PORTS];
  logic [NR_FETCH_PORTS-1:0] eligible;
  logic                any_elig, blocked, req_hs, route, rsp_hs, unexpected, cnt_zero_d;

  // Interface stays quiet during reset and the cycle right after it.
  assign blocked = rst_i | init_q;

  // Round-robin pick of the first eligible port at or after the pointer; a held lock overrides it.
  always_comb begin
    int idx;
    any_elig = 1'b0;
    winner   = lock_idx_q;
    for (int p = 0; p < NP; p++) begin
      eligible[p] = in_valid_i[p] && (cnt_q[p] < CW'(MAX_OUTSTANDING)) &&
                    (state_q == IDLE) && !flush_valid_i && !blocked;
    end
    for (int i = 0; i < NP; i++) begin
      idx = (int'(ptr_q) + i) % NP;
      if (!any_elig && eligible[idx]) begin
        any_elig = 1'b1;
        if (!lock_q) winner = ID_WIDTH'(idx);
      end
    end
    out_valid_o = !blocked && (lock_q || any_elig);
    out_addr_o  = in_addr_i[int'(winner)*FETCH_AW +: FETCH_AW];
    out_id_o    = winner;
    in_ready_o  = '0;
    if (out_valid_o) in_ready_o[winner] = out_ready_i;
    req_hs  = out_valid_o && out_ready_i;
    stall_o = out_valid_o && !out_ready_i;
    ptr_d   = req_hs ? ID_WIDTH'((int'(winner) + 1) % NP) : ptr_q;
  end

  // Route responses by ID to ports that are actually waiting; everything else is sunk.
  always_comb begin
    route = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (!blocked && out_rsp_id_i == ID_WIDTH'(p) && cnt_q[p] != '0) route = 1'b1;
    end
    in_rsp_data_o   = {NR_FETCH_PORTS{out_rsp_data_i}};
    in_rsp_valid_o  = '0;
    in_rsp_error_o  = '0;
    out_rsp_ready_o = 1'b1;
    if (route) begin
      in_rsp_valid_o[out_rsp_id_i] = out_rsp_valid_i;
      in_rsp_error_o[out_rsp_id_i] = out_rsp_error_i;
      out_rsp_ready_o              = in_rsp_ready_i[out_rsp_id_i];
    end
    rsp_hs     = out_rsp_valid_i && out_rsp_ready_o;
    unexpected = out_rsp_valid_i && !route;
  end

  // Per-port in-flight counters; a simultaneous request and response cancel out.
  always_comb begin
    logic inc, dec;
    cnt_zero_d = 1'b1;
    for (int p = 0; p < NP; p++) begin
      inc = req_hs && (winner == ID_WIDTH'(p));
      dec = route && rsp_hs && (out_rsp_id_i == ID_WIDTH'(p));
      cnt_d[p] = cnt_q[p];
      if (inc && !dec)      cnt_d[p] = cnt_q[p] + CW'(1);
      else if (dec && !inc) cnt_d[p] = cnt_q[p] - CW'(1);
      if (cnt_d[p] != '0) cnt_zero_d = 1'b0;
    end
  end

  // Flush sequencing; drain completes once the counts after this cycle's updates are all zero.
  always_comb begin
    state_d       = state_q;
    flush_ready_o = 1'b0;
    case (state_q)
      IDLE:  if (flush_valid_i) state_d = DRAIN;
      DRAIN: begin
        if (!flush_valid_i) state_d = IDLE;
        else if (cnt_zero_d && !lock_q && !req_hs) state_d = DONE;
      end
      DONE: begin
        flush_ready_o = !blocked;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, lock, counters and the sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      perr_q     <= 1'b0;
      init_q     <= 1'b1;
      for (int p = 0; p < NP; p++) cnt_q[p] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_q     <= out_valid_o && !out_ready_i;
      lock_idx_q <= winner;
      perr_q     <= perr_q | unexpected;
      init_q     <= 1'b0;
      for (int p = 0; p < NP; p++) cnt_q[p] <= cnt_d[p];
    end
  end

  assign protocol_error_o = perr_q;

endmodule

// File: tb/tb_snitch_icache_refill_arbiter.sv
// tb/tb_snitch_icache_refill_arbiter.sv - scoreboard bench for the refill arbiter
module tb_snitch_icache_refill_arbiter;
  localparam int N = 2, AW = 32, LW = 128, MO = 4, IW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i;
  logic [N*AW-1:0] in_addr_i;
  logic [N-1:0]    in_valid_i, in_ready_o, in_rsp_error_o, in_rsp_valid_o, in_rsp_ready_i;
  logic [N*LW-1:0] in_rsp_data_o;
  logic [AW-1:0]   out_addr_o;
  logic [IW-1:0]   out_id_o, out_rsp_id_i;
  logic            out_valid_o, out_ready_i, out_rsp_error_i, out_rsp_valid_i, out_rsp_ready_o;
  logic [LW-1:0]   out_rsp_data_i;
  logic            flush_valid_i, flush_ready_o, stall_o, protocol_error_o;

  snitch_icache_refill_arbiter #(
    .NR_FETCH_PORTS(N), .FETCH_AW(AW), .LINE_WIDTH(LW), .MAX_OUTSTANDING(MO), .ID_WIDTH(IW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_addr_i(in_addr_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_rsp_data_o(in_rsp_data_o), .in_rsp_error_o(in_rsp_error_o),
    .in_rsp_valid_o(in_rsp_valid_o), .in_rsp_ready_i(in_rsp_ready_i),
    .out_addr_o(out_addr_o), .out_id_o(out_id_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_rsp_data_i(out_rsp_data_i), .out_rsp_error_i(out_rsp_error_i), .out_rsp_id_i(out_rsp_id_i),
    .out_rsp_valid_i(out_rsp_valid_i), .out_rsp_ready_o(out_rsp_ready_o),
    .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
    .stall_o(stall_o), .protocol_error_o(protocol_error_o)
  );

  int tests = 0;
  int fails = 0;

  int            exp_id_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            exp_rp_q[$];
  logic [LW-1:0] exp_rd_q[$];
  logic          exp_re_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input int id, input logic [AW-1:0] a);
    exp_id_q.push_back(id);
    exp_addr_q.push_back(a);
  endtask

  task automatic send_rsp(input int id, input logic [LW-1:0] d, input logic e);
    exp_rp_q.push_back(id);
    exp_rd_q.push_back(d);
    exp_re_q.push_back(e);
    out_rsp_valid_i = 1'b1;
    out_rsp_id_i    = IW'(id);
    out_rsp_data_i  = d;
    out_rsp_error_i = e;
    tick();
    out_rsp_valid_i = 1'b0;
  endtask

  // Monitor: pop and compare on every L1 request handshake and every L0 response handshake.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (out_valid_o && out_ready_i) begin
        if (exp_id_q.size() == 0) chk("req_unexpected", 1, 0);
        else begin
          chk("req_id", out_id_o, exp_id_q.pop_front());
          chk("req_addr", out_addr_o, exp_addr_q.pop_front());
        end
      end
      for (int p = 0; p < N; p++) begin
        if (in_rsp_valid_o[p] && in_rsp_ready_i[p]) begin
          if (exp_rp_q.size() == 0) chk("rsp_unexpected", 1, 0);
          else begin
            chk("rsp_port", p, exp_rp_q.pop_front());
            chk("rsp_data", in_rsp_data_o[p*LW +: LW], exp_rd_q.pop_front());
            chk("rsp_error", in_rsp_error_o[p], exp_re_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; in_valid_i = 2'b11; in_addr_i = {32'h200, 32'h100};
    in_rsp_ready_i = 2'b11; out_ready_i = 1'b1; out_rsp_data_i = '0; out_rsp_error_i = 1'b0;
    out_rsp_id_i = '0; out_rsp_valid_i = 1'b0; flush_valid_i = 1'b0;

    repeat (3) tick();
    #2;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_rsp_ready", out_rsp_ready_o, 1);
    chk("rst_flush_ready", flush_ready_o, 0);
    chk("rst_perr", protocol_error_o, 0);
    tick(); rst_i = 1'b0; #2;
    chk("init_out_valid", out_valid_o, 0);
    chk("init_in_ready", in_ready_o, 0);
    chk("init_rsp_ready", out_rsp_ready_o, 1);

    // Fairness: both ports valid, grants alternate 0,1,0,1
    for (int i = 0; i < 4; i++) push_req(i % 2, (i % 2) ? 32'h200 : 32'h100);
    for (int i = 0; i < 4; i++) begin
      tick(); #2;
      chk("fair_id", out_id_o, i % 2);
      chk("fair_in_ready", in_ready_o, (i % 2) ? 2'b10 : 2'b01);
    end
    tick(); in_valid_i = 2'b00;
    send_rsp(0, 128'h11, 1'b0);
    send_rsp(1, 128'h22, 1'b0);
    send_rsp(0, 128'h33, 1'b0);
    send_rsp(1, 128'h44, 1'b1);

    // Lock: move pointer to 1, then hold port 0 locked while port 1 arrives
    in_valid_i = 2'b01; in_addr_i[0 +: AW] = 32'h40; push_req(0, 32'h40);
    tick();
    in_addr_i[0 +: AW] = 32'h1000; out_ready_i = 1'b0; #2;
    chk("lock_valid", out_valid_o, 1);
    chk("lock_stall", stall_o, 1);
    chk("lock_addr", out_addr_o, 32'h1000);
    tick(); in_valid_i = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("lock_hold_id", out_id_o, 0);
      chk("lock_hold_addr", out_addr_o, 32'h1000);
      chk("lock_hold_ready", in_ready_o, 2'b00);
      tick();
    end
    out_ready_i = 1'b1; push_req(0, 32'h1000); #2;
    chk("lock_release_ready", in_ready_o, 2'b01);
    tick(); push_req(1, 32'h200); #2;
    chk("lock_next_id", out_id_o, 1);
    tick(); in_valid_i = 2'b00;
    send_rsp(0, 128'h55, 1'b0);
    send_rsp(0, 128'h66, 1'b0);
    send_rsp(1, 128'h77, 1'b0);

    // Backpressure: 4 outstanding blocks port 0 until a response returns
    in_valid_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      in_addr_i[0 +: AW] = 32'h2000 + 32'(16 * i);
      push_req(0, in_addr_i[0 +: AW]); #2;
      chk("bp_ready", in_ready_o[0], 1);
      tick();
    end
    in_addr_i[0 +: AW] = 32'h2040; #2;
    chk("bp_full_ready", in_ready_o[0], 0);
    chk("bp_full_valid", out_valid_o, 0);
    send_rsp(0, 128'h88, 1'b0);
    push_req(0, 32'h2040); #2;
    chk("bp_resume_ready", in_ready_o[0], 1);
    tick(); in_valid_i = 2'b00;
    for (int i = 0; i < 4; i++) send_rsp(0, 128'h90 + 128'(i), 1'b0);

    // Routing with response backpressure on port 1
    in_valid_i = 2'b10; in_addr_i[AW +: AW] = 32'h300; push_req(1, 32'h300);
    tick(); in_valid_i = 2'b00;
    in_rsp_ready_i = 2'b01; out_rsp_valid_i = 1'b1; out_rsp_id_i = 1'b1;
    out_rsp_data_i = 128'hDEAD_BEEF; out_rsp_error_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("route_valid", in_rsp_valid_o, 2'b10);
      chk("route_rsp_ready", out_rsp_ready_o, 0);
      chk("route_error", in_rsp_error_o, 2'b10);
      chk("route_data", in_rsp_data_o[LW +: LW], 128'hDEAD_BEEF);
      tick();
    end
    exp_rp_q.push_back(1); exp_rd_q.push_back(128'hDEAD_BEEF); exp_re_q.push_back(1'b1);
    in_rsp_ready_i = 2'b11; #2;
    chk("route_hs_ready", out_rsp_ready_o, 1);
    tick(); out_rsp_valid_i = 1'b0; out_rsp_error_i = 1'b0; #2;

    // Error: response to port 1 with nothing outstanding is sunk
    chk("perr_before", protocol_error_o, 0);
    out_rsp_valid_i = 1'b1; out_rsp_id_i = 1'b1; out_rsp_data_i = 128'hBAD; #2;
    chk("err_sink_ready", out_rsp_ready_o, 1);
    chk("err_no_valid", in_rsp_valid_o, 2'b00);
    tick(); out_rsp_valid_i = 1'b0; #2;
    chk("perr_set", protocol_error_o, 1);

    // Minimum flush latency with nothing outstanding
    tick(); flush_valid_i = 1'b1; #2;
    chk("flush_min_c0", flush_ready_o, 0);
    tick(); #2;
    chk("flush_min_c1", flush_ready_o, 0);
    tick(); #2;
    chk("flush_min_c2", flush_ready_o, 1);
    tick(); flush_valid_i = 1'b0; #2;
    chk("flush_min_idle", flush_ready_o, 0);

    // Flush drain with two outstanding on port 0
    tick(); in_valid_i = 2'b01; in_addr_i[0 +: AW] = 32'h400; push_req(0, 32'h400);
    tick(); in_addr_i[0 +: AW] = 32'h410; push_req(0, 32'h410);
    tick(); flush_valid_i = 1'b1; #2;
    chk("flush_no_grant", out_valid_o, 0);
    chk("flush_no_ready", in_ready_o, 2'b00);
    tick(); #2;
    chk("drain_no_grant", out_valid_o, 0);
    chk("drain_flush_ready", flush_ready_o, 0);
    send_rsp(0, 128'hA1, 1'b0);
    #2;
    chk("drain_one_left", flush_ready_o, 0);
    send_rsp(0, 128'hA2, 1'b0);
    #2;
    chk("drain_done", flush_ready_o, 1);
    chk("drain_done_no_grant", out_valid_o, 0);
    tick(); flush_valid_i = 1'b0; push_req(0, 32'h410); #2;
    chk("post_flush_ready", flush_ready_o, 0);
    chk("post_flush_grant", out_valid_o, 1);
    tick(); in_valid_i = 2'b00;
    send_rsp(0, 128'hA3, 1'b0);

    #2;
    chk("perr_sticky", protocol_error_o, 1);
    rst_i = 1'b1;
    tick(); #2;
    chk("perr_cleared", protocol_error_o, 0);
    rst_i = 1'b0;
    tick(); tick();
    chk("req_queue_empty", exp_id_q.size(), 0);
    chk("rsp_queue_empty", exp_rp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
